// File: rtl/prio_pkg.sv
// prio_pkg: shared constants, types and helpers for the priority encoder.
//   PE_WIDTH  - default request vector width
//   out_w()   - index width for a given request width, never below 1
//   req_t     - request vector at the default width
//   idx_t     - encoded index at the default width
package prio_pkg;

  localparam int PE_WIDTH = 4;

  // $clog2(1) is 0, which would make a zero-width index; clamp to 1 bit.
  function automatic int out_w(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

  localparam int PE_OUT_W = out_w(PE_WIDTH);

  typedef logic [PE_WIDTH-1:0] req_t;
  typedef logic [PE_OUT_W-1:0] idx_t;

endpackage

// File: rtl/priority_enc_core.sv
// priority_enc_core: combinational MSB-priority encoder.
//   i      - request vector, bit k set means request k is active
//   idx    - index of the highest set bit (0 when i is all zeros)
//   any    - at least one bit of i is set
//   onehot - one-hot of the winning bit, zero when any=0
module priority_enc_core
  import prio_pkg::*;
#(
  parameter int WIDTH = PE_WIDTH,
  parameter int OUT_W = out_w(WIDTH)
) (
  input  logic [WIDTH-1:0] i,
  output logic [OUT_W-1:0] idx,
  output logic             any,
  output logic [WIDTH-1:0] onehot
);

  // Scan upward; each later hit overwrites earlier ones, so the highest
  // set bit is what remains after the loop.
  always_comb begin
    idx    = '0;
    any    = 1'b0;
    onehot = '0;
    for (int k = 0; k < WIDTH; k++) begin
      if (i[k]) begin
        idx       = OUT_W'(k);
        any       = 1'b1;
        onehot    = '0;
        onehot[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/priority_enc.sv
// priority_enc: registered MSB-priority encoder, one cycle latency.
//   clk    - clock, all state changes on the rising edge
//   rst    - synchronous active-high reset, overrides en
//   en     - capture enable, outputs hold while low
//   i      - request vector
//   o      - registered index of the highest set bit of the captured i
//   valid  - registered: captured i had at least one bit set
//   onehot - registered one-hot of the winning bit, zero when valid=0
module priority_enc
  import prio_pkg::*;
#(
  parameter int WIDTH = PE_WIDTH,
  parameter int OUT_W = out_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] i,
  output logic [OUT_W-1:0] o,
  output logic             valid,
  output logic [WIDTH-1:0] onehot
);

  logic [OUT_W-1:0] idx_nxt;
  logic             any_nxt;
  logic [WIDTH-1:0] oh_nxt;

  priority_enc_core #(
    .WIDTH (WIDTH),
    .OUT_W (OUT_W)
  ) u_core (
    .i      (i),
    .idx    (idx_nxt),
    .any    (any_nxt),
    .onehot (oh_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      o      <= '0;
      valid  <= 1'b0;
      onehot <= '0;
    end else if (en) begin
      o      <= idx_nxt;
      valid  <= any_nxt;
      onehot <= oh_nxt;
    end
  end

endmodule

// File: tb/tb_priority_enc.sv
module tb_priority_enc;
  import prio_pkg::*;

  logic       clk = 1'b0;
  logic       rst, en;
  req_t       i;
  logic [1:0] o;
  logic       valid;
  req_t       onehot;
  logic [5:0] i6;
  logic [2:0] o6;
  logic       valid6;
  logic [5:0] onehot6;

  int total = 0;
  int bad   = 0;

  // expected register contents (model state)
  int m_o, m_v, m_oh, m6_o, m6_v, m6_oh;

  always #5 clk = ~clk;

  priority_enc dut (
    .clk(clk), .rst(rst), .en(en), .i(i),
    .o(o), .valid(valid), .onehot(onehot)
  );

  priority_enc #(.WIDTH(6)) dut6 (
    .clk(clk), .rst(rst), .en(en), .i(i6),
    .o(o6), .valid(valid6), .onehot(onehot6)
  );

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Highest set bit via floor(log2(v)).
  function automatic int ref_idx(input int unsigned v);
    return (v == 0) ? 0 : $clog2(v + 1) - 1;
  endfunction

  // Advance the model with the current inputs, clock once, compare.
  task automatic cyc();
    if (rst) begin
      m_o = 0; m_v = 0; m_oh = 0; m6_o = 0; m6_v = 0; m6_oh = 0;
    end else if (en) begin
      m_o  = ref_idx(int'(i));
      m_v  = (i != 0) ? 1 : 0;
      m_oh = m_v ? (1 << m_o) : 0;
      m6_o  = ref_idx(int'(i6));
      m6_v  = (i6 != 0) ? 1 : 0;
      m6_oh = m6_v ? (1 << m6_o) : 0;
    end
    @(posedge clk); #1;
    chk("o", int'(o), m_o);
    chk("valid", int'(valid), m_v);
    chk("onehot", int'(onehot), m_oh);
    chk("o6", int'(o6), m6_o);
    chk("valid6", int'(valid6), m6_v);
    chk("onehot6", int'(onehot6), m6_oh);
  endtask

  initial begin
    m_o = 0; m_v = 0; m_oh = 0; m6_o = 0; m6_v = 0; m6_oh = 0;
    rst = 1'b1; en = 1'b1; i = 4'b1010; i6 = '0;
    // reset held two cycles
    cyc(); chk("rst_o", int'(o), 0); chk("rst_valid", int'(valid), 0);
    cyc(); chk("rst_onehot", int'(onehot), 0);
    rst = 1'b0;
    cyc();
    chk("post_rst_o", int'(o), 3);
    chk("post_rst_valid", int'(valid), 1);
    chk("post_rst_onehot", int'(onehot), 8);

    // exhaustive sweep
    for (int v = 0; v < 16; v++) begin
      i = 4'(v);
      cyc();
      if (v == 0)  chk("spot0_valid", int'(valid), 0);
      if (v == 5)  chk("spot5_o", int'(o), 2);
      if (v == 8)  chk("spot8_o", int'(o), 3);
      if (v == 15) chk("spot15_o", int'(o), 3);
    end

    // hold with en=0
    i = 4'b0010; cyc(); chk("hold_cap", int'(o), 1);
    en = 1'b0; i = 4'b1000;
    for (int n = 0; n < 3; n++) begin
      cyc();
      chk("hold_o", int'(o), 1);
      chk("hold_valid", int'(valid), 1);
    end
    en = 1'b1; cyc(); chk("reen_o", int'(o), 3);

    // zero request
    i = '0; cyc();
    chk("zero_o", int'(o), 0);
    chk("zero_valid", int'(valid), 0);
    chk("zero_onehot", int'(onehot), 0);

    // reset beats enable
    i = 4'b0100; cyc(); chk("pre_rst_o", int'(o), 2);
    rst = 1'b1; cyc();
    chk("rst_en_o", int'(o), 0);
    chk("rst_en_valid", int'(valid), 0);
    rst = 1'b0;

    // width 6 instance
    i6 = 6'b100000; cyc(); chk("w6_a", int'(o6), 5);
    i6 = 6'b010011; cyc(); chk("w6_b", int'(o6), 4);

    // random traffic
    for (int n = 0; n < 300; n++) begin
      i   = 4'($urandom_range(0, 15));
      i6  = 6'($urandom_range(0, 63));
      en  = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 19) == 0);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
